// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - imem request/response, decode and redirect signals of the fetch unit
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
    logic [31:0] drop_count;
`endif

    modport master (
        output imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
`ifdef FETCH_STATS_EN
        output fetch_count, drop_count,
`endif
        input  imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
        input  redirect, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
`ifdef FETCH_STATS_EN
        input  fetch_count, drop_count,
`endif
        output imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
        output redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, single-outstanding imem fetch, 2-entry instruction buffer; FETCH_STATS_EN adds fetch/drop counters
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    instr_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP} state_t;

    state_t      state, state_n;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic [1:0]  count;
    logic        rd_ptr, wr_ptr;
    logic [31:0] instr_mem [0:1];
    logic [31:0] pc_mem    [0:1];

    logic req_valid, handshake, push, pop, drop_resp;

    always_ff @(posedge clock) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= state_n;
    end

    always_comb begin
        state_n   = state;
        req_valid = 1'b0;
        handshake = 1'b0;
        push      = 1'b0;
        drop_resp = 1'b0;
        case (state)
            S_FETCH: begin
                req_valid = reset_n && (count < 2'(FIFO_DEPTH));
                handshake = req_valid && bus.imem_req_ready;
                if (bus.redirect) state_n = handshake ? S_DROP : S_FETCH;
                else if (handshake) state_n = S_WAIT;
            end
            S_WAIT: begin
                if (bus.redirect) begin
                    state_n   = bus.imem_resp_valid ? S_FETCH : S_DROP;
                    drop_resp = bus.imem_resp_valid;
                end else if (bus.imem_resp_valid) begin
                    state_n = S_FETCH;
                    push    = 1'b1;
                end
            end
            S_DROP: begin
                if (bus.imem_resp_valid) begin
                    state_n   = S_FETCH;
                    drop_resp = 1'b1;
                end
            end
            default: state_n = S_FETCH;
        endcase
    end

    // A redirect flush wins over a concurrent decode pop.
    assign pop = (count != 2'd0) && bus.instr_ready && !bus.redirect;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc     <= RESET_PC & ~32'h3;
            req_pc <= 32'h0;
        end else begin
            if (handshake) req_pc <= pc;
            if (bus.redirect)  pc <= {bus.redirect_pc[31:2], 2'b00};
            else if (handshake) pc <= pc + 32'd4;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || bus.redirect) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                instr_mem[wr_ptr] <= bus.imem_resp_data;
                pc_mem[wr_ptr]    <= req_pc;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = pc;
    assign bus.instr_valid    = (count != 2'd0);
    assign bus.instr          = (count != 2'd0) ? instr_mem[rd_ptr] : 32'h0;
    assign bus.instr_pc       = (count != 2'd0) ? pc_mem[rd_ptr]    : 32'h0;

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_q, drop_count_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fetch_count_q <= 32'h0;
            drop_count_q  <= 32'h0;
        end else begin
            if (push)      fetch_count_q <= fetch_count_q + 32'd1;
            if (drop_resp) drop_count_q  <= drop_count_q + 32'd1;
        end
    end

    assign bus.fetch_count = fetch_count_q;
    assign bus.drop_count  = drop_count_q;
`else
    logic unused_drop;
    assign unused_drop = drop_resp;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - table-driven bench for instr_fetch_unit with RESET_PC = 0x100
module tb_instr_fetch_unit;
    logic clock = 1'b0;
    logic reset_n;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rn, rdy, rv;
        logic [31:0] rdata;
        logic        ir, redir;
        logic [31:0] rpc;
        logic        e_rq;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr, e_ipc;
    } vec_t;

    vec_t vecs[$];
    int checks   = 0;
    int failures = 0;

    task automatic add(input logic rn, rdy, rv, input logic [31:0] rdata,
                       input logic ir, redir, input logic [31:0] rpc,
                       input logic e_rq, input logic [31:0] e_addr,
                       input logic e_iv, input logic [31:0] e_instr, e_ipc);
        vec_t v;
        v.rn = rn; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
        v.ir = ir; v.redir = redir; v.rpc = rpc;
        v.e_rq = e_rq; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_instr = e_instr; v.e_ipc = e_ipc;
        vecs.push_back(v);
    endtask

    task automatic check32(input string name, input int idx, input logic [31:0] got, want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s step %0d got %h want %h", name, idx, got, want);
        end
    endtask

    task automatic drive(input logic rn, rdy, rv, input logic [31:0] rdata,
                         input logic ir, redir, input logic [31:0] rpc);
        reset_n             = rn;
        bus.imem_req_ready  = rdy;
        bus.imem_resp_valid = rv;
        bus.imem_resp_data  = rdata;
        bus.instr_ready     = ir;
        bus.redirect        = redir;
        bus.redirect_pc     = rpc;
    endtask

    initial begin
        logic        pending;
        logic [31:0] exp_addr, exp_ipc, pend_addr;
        int          n_req, n_instr;

        // Reset state, then steady fetch with decode always ready.
        add(0,0,0,32'h0,        0,0,32'h0,       0,32'h100,     0,32'h0,        32'h0);
        add(1,1,0,32'h0,        1,0,32'h0,       1,32'h100,     0,32'h0,        32'h0);
        add(1,1,1,32'hA0000100, 1,0,32'h0,       0,32'h104,     0,32'h0,        32'h0);
        add(1,1,0,32'h0,        1,0,32'h0,       1,32'h104,     1,32'hA0000100, 32'h100);
        add(1,1,1,32'hA0000104, 1,0,32'h0,       0,32'h108,     0,32'h0,        32'h0);
        add(1,1,0,32'h0,        1,0,32'h0,       1,32'h108,     1,32'hA0000104, 32'h104);
        add(1,1,1,32'hA0000108, 1,0,32'h0,       0,32'h10C,     0,32'h0,        32'h0);
        // Reset with a buffered entry: request gated off while reset is low.
        add(0,1,0,32'h0,        0,0,32'h0,       0,32'h10C,     1,32'hA0000108, 32'h108);
        // Decode stalled: buffer fills to 2, requests stop until a pop.
        add(1,1,0,32'h0,        0,0,32'h0,       1,32'h100,     0,32'h0,        32'h0);
        add(1,1,1,32'hA0000100, 0,0,32'h0,       0,32'h104,     0,32'h0,        32'h0);
        add(1,1,0,32'h0,        0,0,32'h0,       1,32'h104,     1,32'hA0000100, 32'h100);
        add(1,1,1,32'hA0000104, 0,0,32'h0,       0,32'h108,     1,32'hA0000100, 32'h100);
        add(1,1,0,32'h0,        0,0,32'h0,       0,32'h108,     1,32'hA0000100, 32'h100);
        add(1,1,0,32'h0,        0,0,32'h0,       0,32'h108,     1,32'hA0000100, 32'h100);
        add(1,1,0,32'h0,        1,0,32'h0,       0,32'h108,     1,32'hA0000100, 32'h100);
        add(1,1,0,32'h0,        0,0,32'h0,       1,32'h108,     1,32'hA0000104, 32'h104);
        // Redirect in WAIT without response: late response dropped.
        add(1,1,0,32'h0,        0,1,32'h2003,    0,32'h10C,     1,32'hA0000104, 32'h104);
        add(1,1,1,32'hA0000108, 0,0,32'h0,       0,32'h2000,    0,32'h0,        32'h0);
        add(1,1,0,32'h0,        0,0,32'h0,       1,32'h2000,    0,32'h0,        32'h0);
        // Redirect together with the response in WAIT.
        add(1,1,1,32'hA0002000, 1,1,32'h3000,    0,32'h2004,    0,32'h0,        32'h0);
        add(1,0,0,32'h0,        1,0,32'h0,       1,32'h3000,    0,32'h0,        32'h0);
        // Redirect in the handshake cycle goes to DROP.
        add(1,1,0,32'h0,        1,1,32'hFFFFFFFF,1,32'h3000,    0,32'h0,        32'h0);
        add(1,1,1,32'hDEADBEEF, 1,0,32'h0,       0,32'hFFFFFFFC,0,32'h0,        32'h0);
        // PC wraps past 2^32.
        add(1,1,0,32'h0,        1,0,32'h0,       1,32'hFFFFFFFC,0,32'h0,        32'h0);
        add(1,1,1,32'hA0FFFFFC, 1,0,32'h0,       0,32'h0,       0,32'h0,        32'h0);
        add(1,1,0,32'h0,        0,0,32'h0,       1,32'h0,       1,32'hA0FFFFFC, 32'hFFFFFFFC);
        // Reset while in WAIT; the late response is ignored.
        add(0,1,0,32'h0,        0,0,32'h0,       0,32'h4,       1,32'hA0FFFFFC, 32'hFFFFFFFC);
        add(1,0,1,32'hDEADBEEF, 1,0,32'h0,       1,32'h100,     0,32'h0,        32'h0);
        add(1,1,0,32'h0,        1,0,32'h0,       1,32'h100,     0,32'h0,        32'h0);
        // Push and pop in the same cycle at count 1.
        add(1,1,1,32'hA0000100, 1,0,32'h0,       0,32'h104,     0,32'h0,        32'h0);
        add(1,1,0,32'h0,        0,0,32'h0,       1,32'h104,     1,32'hA0000100, 32'h100);
        add(1,1,1,32'hA0000104, 1,0,32'h0,       0,32'h108,     1,32'hA0000100, 32'h100);
        add(1,0,0,32'h0,        0,0,32'h0,       1,32'h108,     1,32'hA0000104, 32'h104);

        drive(0,0,0,32'h0,0,0,32'h0);
        repeat (2) @(posedge clock);

        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i].rn, vecs[i].rdy, vecs[i].rv, vecs[i].rdata,
                  vecs[i].ir, vecs[i].redir, vecs[i].rpc);
            #1;
            check32("req_valid",   i, {31'h0, bus.imem_req_valid}, {31'h0, vecs[i].e_rq});
            check32("imem_addr",   i, bus.imem_addr,               vecs[i].e_addr);
            check32("instr_valid", i, {31'h0, bus.instr_valid},    {31'h0, vecs[i].e_iv});
            check32("instr",       i, bus.instr,                   vecs[i].e_instr);
            check32("instr_pc",    i, bus.instr_pc,                vecs[i].e_ipc);
        end

`ifdef FETCH_STATS_EN
        check32("fetch_count", 0, bus.fetch_count, 32'd2);
        check32("drop_count",  0, bus.drop_count,  32'd0);
`endif

        // Throughput: zero-wait imem answering next cycle, decode always ready.
        @(negedge clock);
        drive(0,0,0,32'h0,0,0,32'h0);
        repeat (2) @(negedge clock);
        pending   = 1'b0;
        pend_addr = 32'h0;
        exp_addr  = 32'h100;
        exp_ipc   = 32'h100;
        n_req     = 0;
        n_instr   = 0;
        for (int c = 0; c < 20; c++) begin
            drive(1, 1, pending, 32'hA0000000 ^ pend_addr, 1, 0, 32'h0);
            #1;
            if (bus.imem_req_valid) begin
                check32("tp_addr", c, bus.imem_addr, exp_addr);
                exp_addr  = exp_addr + 32'd4;
                pend_addr = bus.imem_addr;
                pending   = 1'b1;
                n_req++;
            end else begin
                pending = 1'b0;
            end
            if (bus.instr_valid) begin
                check32("tp_instr_pc", c, bus.instr_pc, exp_ipc);
                check32("tp_instr",    c, bus.instr,    32'hA0000000 ^ exp_ipc);
                exp_ipc = exp_ipc + 32'd4;
                n_instr++;
            end
            @(negedge clock);
        end
        check32("tp_requests",     0, n_req,   32'd10);
        check32("tp_instructions", 0, n_instr, 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch-side consumer of the program counter.
- Owns the fetch PC and issues word-aligned read requests to instruction memory over a valid/ready request channel.
- Buffers returned instructions, tagged with their PC, in a 2-entry FIFO toward decode.
- Handles redirects (branch/jump) by flushing the buffer and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h00000000, fetch address loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; fixed at 2, not intended to be overridden.

Ports:
- Clock  input  1  single clock; all state updates on rising edge.
- Reset_n  input  1  synchronous, active-low reset.
- ImemReqValid  output  1  fetch request valid.
- ImemReqReady  input  1  imem accepts request this cycle.
- ImemAddr  output  32  fetch address; always equals current PC, bits [1:0] = 0.
- ImemRespValid  input  1  instruction data valid, for the single outstanding request.
- ImemRespData  input  32  instruction word.
- InstrValid  output  1  FIFO head valid toward decode.
- InstrReady  input  1  decode consumes the head.
- Instr  output  32  FIFO head instruction.
- InstrPC  output  32  PC of the FIFO head instruction.
- Redirect  input  1  change fetch stream.
- RedirectPC  input  32  new fetch address; bits [1:0] are ignored and forced to 0.

Behaviour:
- Reset (Reset_n = 0 at a clock edge):
  - PC = RESET_PC & ~3; FIFO empty; state = FETCH.
  - ImemReqValid = 0, InstrValid = 0, Instr = 0, InstrPC = 0.
  - Reset mid-transaction abandons the outstanding request; a late response after reset is ignored because state = FETCH.
- At most one outstanding request.
- State machine:
  - FETCH: no request outstanding. ImemReqValid = 1 iff FIFO count < FIFO_DEPTH and Reset_n = 1. On ImemReqValid & ImemReqReady: PC <= PC + 4, go to WAIT.
  - WAIT: request outstanding, ImemReqValid = 0. On ImemRespValid: push {PC_of_request, ImemRespData}, go to FETCH. Space is guaranteed because a request is issued only when count < depth, and pops only free space.
  - DROP: outstanding response is to be discarded, ImemReqValid = 0. On ImemRespValid: discard it, go to FETCH.
- Request PC is held in an internal register captured at the handshake.
- Redirect, highest priority in every state:
  - PC <= RedirectPC & ~3; FIFO flushed (count = 0, InstrValid = 0 next cycle).
  - From FETCH with a request handshake in the same cycle: go to DROP.
  - From FETCH without a handshake: stay in FETCH.
  - From WAIT with no response this cycle: go to DROP.
  - From WAIT with a response this cycle: drop the response, go to FETCH.
  - From DROP with a response this cycle: go to FETCH; otherwise stay in DROP.
  - Concurrent InstrReady pop is overridden by the flush.
- FIFO:
  - InstrValid = count != 0; Instr/InstrPC show the head.
  - Pop on InstrValid & InstrReady.
  - Simultaneous push and pop when count = 1 or 2 leaves count unchanged with order preserved.
  - Push into empty FIFO: data visible the cycle after ImemRespValid (1-cycle response-to-decode latency).
- Timing and arithmetic:
  - Throughput is one instruction per 2 cycles with zero-wait imem. It stalls when the FIFO is full and decode holds InstrReady = 0.
  - PC arithmetic is modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000.
  - ImemRespValid in state FETCH (no outstanding request) is ignored.
  - ImemAddr may change while ImemReqValid = 1 and not yet accepted, on redirect only; imem samples the address only at the handshake.

Optional Feature:
- Macro: FETCH_STATS_EN.
- When defined, adds two outputs:
  - FetchCount (32-bit): responses pushed into the FIFO.
  - DropCount (32-bit): responses discarded in DROP, plus the response dropped on a redirect in WAIT.
- Both counters reset to 0 and wrap at 2^32.
- When not defined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC = 0x100, imem ready every cycle and responding the next cycle, decode always ready -> addresses 0x100, 0x104, 0x108; InstrPC sequence matches; one request per 2 cycles.
- Decode holds InstrReady = 0 -> exactly 2 instructions buffered; ImemReqValid stays 0 until a pop; PCs 0x100 and 0x104 are held in order.
- Redirect to 0x2003 one cycle after a request handshake at 0x108 -> response for 0x108 dropped; next ImemAddr = 0x2000; FIFO empty the cycle after the redirect.
- Redirect in the same cycle as ImemRespValid in WAIT -> response not pushed; FETCH next cycle with PC = RedirectPC.
- Redirect to 0xFFFFFFFC, then fetch -> addresses 0xFFFFFFFC, then 0x00000000.
- Reset_n low while in WAIT, response arrives 1 cycle later -> nothing pushed; first post-reset request goes to RESET_PC; with FETCH_STATS_EN, both counters read 0.
